// File: rtl/frame_seq_ctrl.sv
// Frame sequencer: aligns runs to vsync boundaries, rotates the source buffer and shadows the mode per frame.
// Define FRAME_CHECK_EN to build the line/frame geometry checker (err_short/err_long); otherwise both read 0.
module frame_seq_ctrl #(
   parameter int NUM_SRC = 3,
   parameter int H_ACT   = 1280,
   parameter int V_ACT   = 720,
   parameter bit VS_POL  = 1'b1,
   parameter int CNT_W   = 12,
   localparam int SRC_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_vsync,
   input  logic             in_hsync,
   input  logic             in_de,
   input  logic             start,
   input  logic             stop,
   input  logic [1:0]       cfg_mode,
   input  logic [CNT_W-1:0] cfg_frames,
   output logic             busy,
   output logic [SRC_W-1:0] src_sel,
   output logic [1:0]       mode,
   output logic [CNT_W-1:0] frame_cnt,
   output logic             frame_done,
   output logic             err_short,
   output logic             err_long
);

   // state    | meaning
   // S_IDLE   | no run; outputs hold, waiting for start
   // S_ARM    | run accepted, waiting for the first frame boundary
   // S_ACTIVE | counting frames, one frame_done per boundary
   typedef enum logic [1:0] {S_IDLE, S_ARM, S_ACTIVE} state_t;

   state_t           state_q, state_d;
   logic             vs_q, vs_n, fb;
   logic             stop_pend_q, stop_pend_d;
   logic [CNT_W-1:0] frames_q, frames_d;
   logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d, cnt_inc;
   logic [SRC_W-1:0] src_q, src_d;
   logic [1:0]       mode_q, mode_d;
   logic             done_q, done_d;
   logic             clr_err, geo_clr;
   logic             unused_ok;

   assign vs_n    = VS_POL ? in_vsync : ~in_vsync;
   assign fb      = vs_q & ~vs_n;
   assign cnt_inc = frame_cnt_q + 1'b1;

   always_comb begin
      state_d     = state_q;
      stop_pend_d = stop_pend_q;
      frames_d    = frames_q;
      frame_cnt_d = frame_cnt_q;
      src_d       = src_q;
      mode_d      = mode_q;
      done_d      = 1'b0;
      clr_err     = 1'b0;
      geo_clr     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               frames_d    = cfg_frames;
               mode_d      = cfg_mode;
               frame_cnt_d = '0;
               src_d       = '0;
               stop_pend_d = 1'b0;
               clr_err     = 1'b1;
               state_d     = S_ARM;
            end
         end
         S_ARM: begin
            if (stop) stop_pend_d = 1'b1;
            if (fb) begin
               geo_clr = 1'b1;
               state_d = S_ACTIVE;
            end
         end
         S_ACTIVE: begin
            if (stop) stop_pend_d = 1'b1;
            if (fb) begin
               done_d      = 1'b1;
               frame_cnt_d = cnt_inc;
               // the finishing boundary leaves src_sel/mode on the last frame's values
               if (stop_pend_q || stop || (frames_q != '0 && cnt_inc == frames_q)) begin
                  stop_pend_d = 1'b0;
                  state_d     = S_IDLE;
               end else begin
                  src_d  = (src_q == SRC_W'(NUM_SRC - 1)) ? '0 : src_q + 1'b1;
                  mode_d = cfg_mode;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         vs_q        <= 1'b0;
         stop_pend_q <= 1'b0;
         frames_q    <= '0;
         frame_cnt_q <= '0;
         src_q       <= '0;
         mode_q      <= 2'b00;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         vs_q        <= vs_n;
         stop_pend_q <= stop_pend_d;
         frames_q    <= frames_d;
         frame_cnt_q <= frame_cnt_d;
         src_q       <= src_d;
         mode_q      <= mode_d;
         done_q      <= done_d;
      end
   end

`ifdef FRAME_CHECK_EN
   logic             de_q, de_fall;
   logic [CNT_W-1:0] pix_q, pix_d, line_q, line_d, line_eff;
   logic             es_q, es_d, el_q, el_d;

   assign de_fall  = de_q & ~in_de;
   // a line ending on the boundary cycle still belongs to the closing frame
   assign line_eff = (de_fall && line_q != '1) ? line_q + 1'b1 : line_q;

   always_comb begin
      pix_d  = pix_q;
      line_d = line_q;
      es_d   = es_q;
      el_d   = el_q;
      if (clr_err) begin
         es_d = 1'b0;
         el_d = 1'b0;
      end
      if (geo_clr) begin
         pix_d  = '0;
         line_d = '0;
      end else if (state_q == S_ACTIVE) begin
         if (in_de && pix_q != '1) pix_d = pix_q + 1'b1;
         if (de_fall) begin
            if (pix_q < CNT_W'(H_ACT)) es_d = 1'b1;
            if (pix_q > CNT_W'(H_ACT)) el_d = 1'b1;
            pix_d  = '0;
            line_d = line_eff;
         end
         if (fb) begin
            if (line_eff < CNT_W'(V_ACT)) es_d = 1'b1;
            if (line_eff > CNT_W'(V_ACT)) el_d = 1'b1;
            line_d = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         de_q   <= 1'b0;
         pix_q  <= '0;
         line_q <= '0;
         es_q   <= 1'b0;
         el_q   <= 1'b0;
      end else begin
         de_q   <= in_de;
         pix_q  <= pix_d;
         line_q <= line_d;
         es_q   <= es_d;
         el_q   <= el_d;
      end
   end

   assign err_short = es_q;
   assign err_long  = el_q;
`else
   assign err_short = 1'b0;
   assign err_long  = 1'b0;
`endif

   // hsync is observed only; de and the checker strobes go unused without the checker
   assign unused_ok = ^{in_hsync, in_de, clr_err, geo_clr};

   assign busy       = (state_q != S_IDLE);
   assign src_sel    = src_q;
   assign mode       = mode_q;
   assign frame_cnt  = frame_cnt_q;
   assign frame_done = done_q;

endmodule

// File: tb/tb_frame_seq_ctrl.sv
// Scoreboard bench for frame_seq_ctrl: a run-level model predicts each frame_done, a monitor compares.
module tb_frame_seq_ctrl;
   localparam int NUM_SRC = 3;
   localparam int H_ACT   = 8;
   localparam int V_ACT   = 4;
   localparam int CNT_W   = 4;
   localparam bit VS_POL  = 1'b1;
   localparam int SRC_W   = $clog2(NUM_SRC);
`ifdef FRAME_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst, in_vsync, in_hsync, in_de, start, stop;
   logic [1:0]       cfg_mode;
   logic [CNT_W-1:0] cfg_frames;
   logic             busy, frame_done, err_short, err_long;
   logic [SRC_W-1:0] src_sel;
   logic [1:0]       mode;
   logic [CNT_W-1:0] frame_cnt;

   frame_seq_ctrl #(.NUM_SRC(NUM_SRC), .H_ACT(H_ACT), .V_ACT(V_ACT), .VS_POL(VS_POL), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .in_vsync(in_vsync), .in_hsync(in_hsync), .in_de(in_de),
      .start(start), .stop(stop), .cfg_mode(cfg_mode), .cfg_frames(cfg_frames),
      .busy(busy), .src_sel(src_sel), .mode(mode), .frame_cnt(frame_cnt),
      .frame_done(frame_done), .err_short(err_short), .err_long(err_long));

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int failures = 0;

   typedef struct {int cyc; int cnt; int src; int mode; int busy; int es; int el;} exp_t;
   exp_t sb[$];

   // run-level model: is a run accepted, has it seen its first boundary, what has it produced
   bit m_busy, m_live, m_pend, m_es, m_el;
   int m_cnt, m_target, m_src, m_mode, m_lines;

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic model_reset();
      m_busy = 0; m_live = 0; m_pend = 0; m_es = 0; m_el = 0;
      m_cnt = 0; m_target = 0; m_src = 0; m_mode = 0; m_lines = 0;
      sb.delete();
   endtask

   task automatic model_start();
      if (!m_busy) begin
         m_busy = 1; m_live = 0; m_pend = 0; m_es = 0; m_el = 0;
         m_target = int'(cfg_frames); m_mode = int'(cfg_mode); m_cnt = 0; m_src = 0;
      end
   endtask

   task automatic model_line(int n);
      if (m_live) begin
         if (n < H_ACT) m_es = 1;
         if (n > H_ACT) m_el = 1;
         m_lines++;
      end
   endtask

   task automatic model_fb(bit stop_now);
      exp_t e;
      bit   fin;
      if (m_busy && !m_live) begin
         m_live = 1; m_lines = 0;
         if (stop_now) m_pend = 1;
      end else if (m_live) begin
         m_cnt = (m_cnt + 1) % (1 << CNT_W);
         if (m_lines < V_ACT) m_es = 1;
         if (m_lines > V_ACT) m_el = 1;
         m_lines = 0;
         fin = m_pend || stop_now || (m_target != 0 && m_cnt == m_target);
         if (fin) begin
            m_busy = 0; m_live = 0; m_pend = 0;
         end else begin
            m_src  = (m_src + 1) % NUM_SRC;
            m_mode = int'(cfg_mode);
         end
         e = '{cyc + 1, m_cnt, m_src, m_mode, int'(m_busy), CHK ? int'(m_es) : 0, CHK ? int'(m_el) : 0};
         sb.push_back(e);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start();
      start = 1; model_start(); tick(); start = 0;
   endtask

   task automatic do_stop();
      stop = 1; if (m_busy) m_pend = 1; tick(); stop = 0;
   endtask

   task automatic line(int n);
      in_de = 1; repeat (n) tick();
      in_de = 0; model_line(n);
      in_hsync = 1; tick(); in_hsync = 0; tick(); tick();
   endtask

   task automatic vs_edge(bit stop_now);
      in_vsync = VS_POL; tick(); tick();
      in_vsync = !VS_POL; stop = stop_now; model_fb(stop_now); tick(); stop = 0;
      tick(); tick();
   endtask

   task automatic frame(int nl, int bad, int badpix, bit stop_now);
      for (int i = 0; i < nl; i++) line(i == bad ? badpix : H_ACT);
      vs_edge(stop_now);
   endtask

   task automatic chk_reset_vals(string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_src_sel"}, src_sel, 0);
      chk({tag, "_mode"}, mode, 0);
      chk({tag, "_frame_cnt"}, frame_cnt, 0);
      chk({tag, "_frame_done"}, frame_done, 0);
      chk({tag, "_err_short"}, err_short, 0);
      chk({tag, "_err_long"}, err_long, 0);
   endtask

   // monitor: every frame_done must match the oldest prediction, on the predicted cycle
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         if (frame_done === 1'b1) begin
            if (sb.size() == 0) chk("spurious_frame_done", frame_done, 0);
            else begin
               e = sb.pop_front();
               chk("done_cycle", cyc, e.cyc);
               chk("done_frame_cnt", frame_cnt, e.cnt);
               chk("done_src_sel", src_sel, e.src);
               chk("done_mode", mode, e.mode);
               chk("done_busy", busy, e.busy);
               chk("done_err_short", err_short, e.es);
               chk("done_err_long", err_long, e.el);
            end
         end else if (sb.size() > 0 && sb[0].cyc < cyc) begin
            chk("missing_frame_done", frame_done, 1);
            void'(sb.pop_front());
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog_timeout cycle=%0d required=finish", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1; in_vsync = !VS_POL; in_hsync = 0; in_de = 0; start = 0; stop = 0;
      cfg_mode = 0; cfg_frames = 0;
      model_reset();
      repeat (3) tick();
      chk_reset_vals("reset");
      rst = 0; tick();

      // fixed-length run: first boundary arms, three frames, then idle
      cfg_frames = 3; cfg_mode = 0;
      line(H_ACT);
      do_start();
      chk("busy_after_start", busy, 1);
      vs_edge(0);
      repeat (4) frame(V_ACT, -1, 0, 0);
      chk("t1_busy", busy, 0);
      chk("t1_frame_cnt", frame_cnt, 3);
      chk("t1_src_sel", src_sel, 2);

      // continuous run, stop requested mid-frame 7
      cfg_frames = 0;
      do_start();
      vs_edge(0);
      repeat (6) frame(V_ACT, -1, 0, 0);
      line(H_ACT); line(H_ACT); do_stop(); line(H_ACT); line(H_ACT);
      vs_edge(0);
      chk("t2_busy", busy, 0);
      chk("t2_frame_cnt", frame_cnt, 7);
      chk("t2_src_sel", src_sel, 0);

      // mode shadowing
      cfg_mode = 1; cfg_frames = 2;
      do_start();
      vs_edge(0);
      line(H_ACT); line(H_ACT); cfg_mode = 3; line(H_ACT);
      chk("t3_mode_held", mode, 1);
      line(H_ACT);
      vs_edge(0);
      frame(V_ACT, -1, 0, 0);
      chk("t3_mode_final", mode, 3);

      // geometry errors, stop coinciding with a boundary
      cfg_mode = 2; cfg_frames = 0;
      do_start();
      vs_edge(0);
      line(H_ACT); line(7);
      chk("t4_err_short_line", err_short, CHK);
      line(H_ACT); line(H_ACT);
      vs_edge(0);
      frame(V_ACT, -1, 0, 1);
      chk("t4_err_short_sticky", err_short, CHK);
      do_start();
      chk("t4_err_short_cleared", err_short, 0);
      chk("t4_err_long_cleared", err_long, 0);
      vs_edge(0);
      frame(V_ACT + 1, -1, 0, 1);
      chk("t4_err_long_frame", err_long, CHK);
      chk("t4_busy", busy, 0);

      // vsync already active while reset is released
      rst = 1; in_vsync = VS_POL; model_reset();
      repeat (2) tick();
      rst = 0; tick(); tick();
      cfg_frames = 1; cfg_mode = 0;
      do_start(); tick();
      in_vsync = !VS_POL; model_fb(0); tick(); tick();
      frame(V_ACT, -1, 0, 0);
      chk("t5_busy", busy, 0);
      chk("t5_frame_cnt", frame_cnt, 1);

      // start while busy is ignored, then reset mid-run
      cfg_frames = 0;
      do_start();
      vs_edge(0);
      frame(V_ACT, -1, 0, 0);
      line(H_ACT); do_start(); line(H_ACT); line(H_ACT); line(H_ACT);
      vs_edge(0);
      chk("t6_frame_cnt_kept", frame_cnt, 2);
      line(H_ACT);
      rst = 1; tick(); rst = 0; model_reset();
      chk_reset_vals("midrun_rst");
      line(H_ACT); line(H_ACT); line(H_ACT);
      vs_edge(0);

      // continuous run across the frame counter wrap
      cfg_frames = 0; cfg_mode = 1;
      do_start();
      vs_edge(0);
      repeat (16) frame(V_ACT, -1, 0, 0);
      line(H_ACT); do_stop(); line(H_ACT); line(H_ACT); line(H_ACT);
      vs_edge(0);
      chk("t7_frame_cnt_wrapped", frame_cnt, 1);

      // randomized runs
      for (int it = 0; it < 40; it++) begin
         int nl, bad, bp, stop_line;
         if ($urandom_range(0, 2) == 0) begin
            cfg_frames = CNT_W'($urandom_range(0, 4));
            cfg_mode   = 2'($urandom_range(0, 3));
            do_start();
         end
         nl = V_ACT;
         if ($urandom_range(0, 7) == 0) nl = $urandom_range(0, 1) ? V_ACT + 1 : V_ACT - 1;
         bad = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, nl - 1)) : -1;
         bp  = $urandom_range(1, H_ACT + 2);
         stop_line = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, nl - 1)) : -1;
         for (int i = 0; i < nl; i++) begin
            line(i == bad ? bp : H_ACT);
            if ($urandom_range(0, 3) == 0) cfg_mode = 2'($urandom_range(0, 3));
            if (i == stop_line) do_stop();
         end
         vs_edge($urandom_range(0, 11) == 0);
      end

      repeat (5) tick();
      chk("scoreboard_drained", sb.size(), 0);
      chk("final_busy", busy, m_busy);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/frame_seq_ctrl.md
Name: frame_seq_ctrl

Overview:
Frame-level sequencer for the image-processing chain (timing generator -> rgb2ycbcr -> image_relifing -> BMP writer). It aligns to frame boundaries from the video timing, chooses which source image buffer feeds each frame, and holds the processing-mode configuration stable for a whole frame. It also runs a fixed number of frames, or runs continuously, and reports frame completion and frame-geometry errors to the bench or host.

Parameters:
NUM_SRC, 3, number of source image buffers; src_sel cycles 0..NUM_SRC-1
H_ACT, 1280, expected DE-high pixels per line
V_ACT, 720, expected active lines per frame
VS_POL, 1, in_vsync active level (1 = active-high)
CNT_W, 12, width of frame, pixel and line counters

Ports:
clk  in  1  pixel clock
rst  in  1  synchronous reset, active-high
in_vsync  in  1  vertical sync from timing generator
in_hsync  in  1  horizontal sync (monitored only)
in_de  in  1  data enable from timing generator
start  in  1  one-cycle run request
stop  in  1  one-cycle request to stop at the next frame boundary
cfg_mode  in  2  00 bypass RGB, 01 gray (Y), 10 inverted gray, 11 relief
cfg_frames  in  CNT_W  frames to run; 0 = continuous
busy  out  1  run in progress (ARM or ACTIVE)
src_sel  out  $clog2(NUM_SRC)  source buffer index for the current frame
mode  out  2  shadowed cfg_mode, applied to the current frame
frame_cnt  out  CNT_W  completed frames since start
frame_done  out  1  one-cycle pulse at each frame boundary while ACTIVE
err_short  out  1  sticky: a line or frame had fewer pixels/lines than expected
err_long  out  1  sticky: a line or frame had more pixels/lines than expected

Behaviour:
- Single clock domain. Reset is synchronous and active-high on clk.
- Reset values: busy=0, src_sel=0, mode=0, frame_cnt=0, frame_done=0, err_*=0. State = IDLE. Internal vs_r=0 and de_r=0.
- vs_n = in_vsync normalised by VS_POL. Frame boundary fb = vs_r & ~vs_n, i.e. the active-to-inactive edge. This matches the bench frame counter.
- Because vs_r resets to 0, there is no false fb when vsync is already active as reset is released.
- States:
  - IDLE: on start, latch cfg_frames and cfg_mode into mode, clear frame_cnt and err_*, set src_sel=0, then go to ARM. stop is ignored in IDLE.
  - ARM (busy=1): wait for fb; this fb does not pulse frame_done. Go to ACTIVE and clear the pixel and line counters.
  - ACTIVE (busy=1): on each fb:
    - frame_done=1 for exactly one cycle (registered; high during the cycle after the edge that sampled fb).
    - frame_cnt += 1.
    - src_sel wraps from NUM_SRC-1 to 0.
    - mode <= cfg_mode, so a mode change takes effect only at a frame boundary.
    - Run the geometry check.
    - If stop is pending, or cfg_frames != 0 and frame_cnt+1 == cfg_frames: go to IDLE with busy=0 in the same cycle frame_done rises. src_sel and mode hold their values.
- start while busy is ignored.
- stop while busy sets stop_pend. stop_pend clears on entry to IDLE. stop and fb in the same cycle counts as pending, so the run stops at that boundary.
- frame_cnt wraps to 0 after 2^CNT_W-1 in continuous mode; the run does not stop.
- Geometry counters (ACTIVE only):
  - pix counts in_de cycles per line.
  - On the DE falling edge: compare pix with H_ACT, line += 1, pix clears.
  - At fb: compare line with V_ACT, then clear line.
  - Any mismatch sets err_short or err_long. Both flags are sticky until the next accepted start.
  - Counters saturate at all-ones.
- rst mid-run returns to the reset values within one cycle. No frame_done is emitted.

Optional Feature:
FRAME_CHECK_EN
- Defined: the geometry counters and err_short/err_long are built as described.
- Undefined: no pix/line counters are instantiated, err_short and err_long are tied to 0, and sequencing is unchanged.

Test Plan:
1. H_ACT=8, V_ACT=4, NUM_SRC=3, cfg_frames=3, start, then 5 frames of timing -> first fb only arms; frame_done pulses on fb 2, 3 and 4; src_sel goes 0,1,2; after the third pulse busy=0, frame_cnt=3, src_sel holds 2; no pulse on fb 5.
2. cfg_frames=0, run 7 frames -> src_sel goes 0,1,2,0,1,2,0; busy stays 1; stop mid-frame 7 -> at the next fb frame_done=1, busy=0, frame_cnt=7.
3. cfg_mode=01 at start, changed to 11 mid-frame -> mode stays 01 until the next fb, then becomes 11 in the frame_done cycle.
4. With FRAME_CHECK_EN: one line of 7 DE cycles -> err_short=1 at that line end and it stays 1. Next start -> cleared. 5 lines in a frame -> err_long=1.
5. vsync already high as rst deasserts, start issued -> no spurious fb; the first real fb arms and the second gives the first frame_done.
6. rst asserted for 1 cycle while ACTIVE at frame 2 -> all outputs return to reset values on the next clk edge; start while busy is ignored (frame_cnt not cleared).
